// File: rtl/risc8_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// risc8_mem_arbiter_if
//
// Bundles the three buses around the risc8 memory arbiter:
//   cpu_*  : CPU datapath request/response (req, we, addr, wdata -> rdata,
//            ack, stall)
//   dma_*  : secondary master request/response (req, we, addr, wdata ->
//            rdata, ack, gnt)
//   mem_*  : the single shared memory port (en, we, addr, wdata <- rdata)
//
// Modports:
//   slave  : the arbiter side (takes requests, drives the memory port)
//   master : the environment side (requesters and memory)
// ---------------------------------------------------------------------------
interface risc8_mem_arbiter_if;
   // CPU side
   logic        cpu_req;
   logic        cpu_we;
   logic [23:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ack;
   logic        cpu_stall;

   // secondary master side
   logic        dma_req;
   logic        dma_we;
   logic [23:0] dma_addr;
   logic [15:0] dma_wdata;
   logic [15:0] dma_rdata;
   logic        dma_ack;
   logic        dma_gnt;

   // memory port
   logic        mem_en;
   logic        mem_we;
   logic [23:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_ack, dma_gnt,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_ack, dma_gnt,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/risc8_mem_arbiter.sv
// ---------------------------------------------------------------------------
// risc8_mem_arbiter
//
// Shares the single 16-bit / 24-bit-addressed memory port of the risc8 core
// between the CPU datapath and a secondary master (DMA or COM bridge).
// Accesses never overlap: IDLE (arbitrate) -> ISSUE (strobe the port) ->
// WAIT (reads only, RD_LAT cycles from the issue edge) -> IDLE.
// The CPU has priority; a saturating starvation counter forces one DMA
// grant after STARVE_MAX consecutive contested CPU grants.
//
// Parameters:
//   RD_LAT     : read latency from the issue edge to valid mem_rdata (1..4)
//   STARVE_MAX : contested CPU grants before the DMA is forced (1..15)
// Ports:
//   clk        : clock
//   rst        : synchronous, active-high reset
//   bus.slave  : cpu_* / dma_* request buses and the mem_* port
// ---------------------------------------------------------------------------
module risc8_mem_arbiter #(
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   risc8_mem_arbiter_if.slave bus
);

   localparam logic [1:0] WAIT_LOAD  = 2'(RD_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state_reg,      state_next;
   logic        owner_dma_reg,  owner_dma_next;   // 1 = DMA owns the access
   logic        acc_we_reg,     acc_we_next;      // direction of the access
   logic [1:0]  wait_cnt_reg,   wait_cnt_next;
   logic [3:0]  starve_cnt_reg, starve_cnt_next;
   logic        mem_en_reg,     mem_en_next;
   logic        mem_we_reg,     mem_we_next;
   logic [23:0] mem_addr_reg,   mem_addr_next;
   logic [15:0] mem_wdata_reg,  mem_wdata_next;
   logic [15:0] cpu_hold_reg,   cpu_hold_next;
   logic [15:0] dma_hold_reg,   dma_hold_next;

   logic        grant_dma;
   logic        wr_done;
   logic        rd_done;
   logic        done;
   logic        cpu_ack_int;
   logic        dma_ack_int;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         owner_dma_reg  <= 1'b0;
         acc_we_reg     <= 1'b0;
         wait_cnt_reg   <= 2'd0;
         starve_cnt_reg <= 4'd0;
         mem_en_reg     <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= 24'd0;
         mem_wdata_reg  <= 16'd0;
         cpu_hold_reg   <= 16'd0;
         dma_hold_reg   <= 16'd0;
      end else begin
         state_reg      <= state_next;
         owner_dma_reg  <= owner_dma_next;
         acc_we_reg     <= acc_we_next;
         wait_cnt_reg   <= wait_cnt_next;
         starve_cnt_reg <= starve_cnt_next;
         mem_en_reg     <= mem_en_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         cpu_hold_reg   <= cpu_hold_next;
         dma_hold_reg   <= dma_hold_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state, arbitration and registered-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      owner_dma_next  = owner_dma_reg;
      acc_we_next     = acc_we_reg;
      wait_cnt_next   = wait_cnt_reg;
      starve_cnt_next = starve_cnt_reg;
      mem_en_next     = mem_en_reg;
      mem_we_next     = mem_we_reg;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      cpu_hold_next   = cpu_hold_reg;
      dma_hold_next   = dma_hold_reg;
      grant_dma       = 1'b0;
      wr_done         = 1'b0;
      rd_done         = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (bus.cpu_req || bus.dma_req) begin
               // CPU wins a tie unless the DMA has been passed over
               // STARVE_MAX times in a row.
               grant_dma = bus.dma_req &&
                           (!bus.cpu_req || (starve_cnt_reg == STARVE_LIM));

               state_next     = ISSUE;
               owner_dma_next = grant_dma;
               acc_we_next    = grant_dma ? bus.dma_we    : bus.cpu_we;
               mem_en_next    = 1'b1;
               mem_we_next    = grant_dma ? bus.dma_we    : bus.cpu_we;
               mem_addr_next  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
               mem_wdata_next = grant_dma ? bus.dma_wdata : bus.cpu_wdata;

               // Only a CPU grant that actually beat a waiting DMA counts
               // as starvation.
               if (!grant_dma && bus.dma_req) begin
                  if (starve_cnt_reg != STARVE_LIM) begin
                     starve_cnt_next = starve_cnt_reg + 4'd1;
                  end
               end else begin
                  starve_cnt_next = 4'd0;
               end
            end
         end

         ISSUE: begin
            // The memory samples the port at the edge ending ISSUE, so the
            // strobe drops here for both writes and reads.
            mem_en_next = 1'b0;
            mem_we_next = 1'b0;
            if (acc_we_reg) begin
               wr_done    = 1'b1;
               state_next = IDLE;
            end else begin
               state_next    = WAIT;
               wait_cnt_next = WAIT_LOAD;
            end
         end

         WAIT: begin
            if (wait_cnt_reg == 2'd0) begin
               rd_done    = 1'b1;
               state_next = IDLE;
               if (owner_dma_reg) begin
                  dma_hold_next = bus.mem_rdata;
               end else begin
                  cpu_hold_next = bus.mem_rdata;
               end
            end else begin
               wait_cnt_next = wait_cnt_reg - 2'd1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Combinational outputs
   // ------------------------------------------------------------------
   // A completion in the same cycle that reset is asserted is treated as
   // aborted: the access is thrown away, so it must not be acknowledged.
   assign done        = (wr_done || rd_done) && !rst;
   assign cpu_ack_int = done && !owner_dma_reg;
   assign dma_ack_int = done &&  owner_dma_reg;

   assign bus.cpu_ack   = cpu_ack_int;
   assign bus.dma_ack   = dma_ack_int;
   assign bus.dma_gnt   = owner_dma_reg && (state_reg != IDLE);
   assign bus.cpu_stall = bus.cpu_req && !cpu_ack_int;

   // Read data is passed straight through in the ack cycle so the datapath
   // sees it without an extra register stage; otherwise the held copy.
   assign bus.cpu_rdata = (rd_done && !rst && !owner_dma_reg) ? bus.mem_rdata
                                                              : cpu_hold_reg;
   assign bus.dma_rdata = (rd_done && !rst &&  owner_dma_reg) ? bus.mem_rdata
                                                              : dma_hold_reg;

   assign bus.mem_en    = mem_en_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_risc8_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_risc8_mem_arbiter
//
// Two arbiters share clk/rst: u_dut1 with RD_LAT=1 and u_dut3 with RD_LAT=3,
// both STARVE_MAX=4. Each has a small word memory behind its port. Every
// access pushes its expected owner/data into that DUT's queue; a monitor pops
// and compares at each ack. Scenario tasks add inline timing checks.
// ---------------------------------------------------------------------------
module tb_risc8_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   risc8_mem_arbiter_if b1 ();
   risc8_mem_arbiter_if b3 ();

   risc8_mem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   risc8_mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b3.slave)
   );

   // ---------------- memory models ----------------
   bit   [15:0] mem1 [256];
   bit   [15:0] mem3 [256];
   logic [15:0] rd1    = 16'h0;
   logic [15:0] rd3    = 16'h0;
   logic [15:0] noise3 = 16'h0;

   always @(posedge clk) begin
      if (b1.mem_en) begin
         if (b1.mem_we) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
         else           rd1 <= mem1[b1.mem_addr[7:0]];
      end
      if (b3.mem_en) begin
         if (b3.mem_we) mem3[b3.mem_addr[7:0]] <= b3.mem_wdata;
         else           rd3 <= mem3[b3.mem_addr[7:0]];
      end
   end

   assign b1.mem_rdata = rd1;
   assign b3.mem_rdata = rd3 ^ noise3;

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        dma;
      logic        rd;
      logic [15:0] data;
   } exp_t;

   exp_t sb1[$];
   exp_t sb3[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(input logic dma, input logic rd, input logic [15:0] d);
      exp_t e;
      e.dma  = dma;
      e.rd   = rd;
      e.data = d;
      return e;
   endfunction

   exp_t        e1, e3;
   logic [15:0] got1, got3;

   always @(negedge clk) begin
      if (b1.cpu_ack || b1.dma_ack) begin
         checks++;
         if (sb1.size() == 0) begin
            errors++;
            $display("FAIL dut1_unexpected_ack: cpu_ack=%0b dma_ack=%0b, expected no ack", b1.cpu_ack, b1.dma_ack);
         end else begin
            e1 = sb1.pop_front();
            if ({b1.dma_ack, b1.cpu_ack} !== {e1.dma, ~e1.dma}) begin
               errors++;
               $display("FAIL dut1_owner: dma_ack,cpu_ack=%b expected %b", {b1.dma_ack, b1.cpu_ack}, {e1.dma, ~e1.dma});
            end
            got1 = e1.dma ? b1.dma_rdata : b1.cpu_rdata;
            if (e1.rd) begin
               checks++;
               if (got1 !== e1.data) begin
                  errors++;
                  $display("FAIL dut1_rdata: got %h expected %h", got1, e1.data);
               end
            end
            $display("dut1 t=%0t ack %s %s data=%h", $time, e1.dma ? "DMA" : "CPU", e1.rd ? "RD" : "WR", got1);
         end
      end
      if (b3.cpu_ack || b3.dma_ack) begin
         checks++;
         if (sb3.size() == 0) begin
            errors++;
            $display("FAIL dut3_unexpected_ack: cpu_ack=%0b dma_ack=%0b, expected no ack", b3.cpu_ack, b3.dma_ack);
         end else begin
            e3 = sb3.pop_front();
            if ({b3.dma_ack, b3.cpu_ack} !== {e3.dma, ~e3.dma}) begin
               errors++;
               $display("FAIL dut3_owner: dma_ack,cpu_ack=%b expected %b", {b3.dma_ack, b3.cpu_ack}, {e3.dma, ~e3.dma});
            end
            got3 = e3.dma ? b3.dma_rdata : b3.cpu_rdata;
            if (e3.rd) begin
               checks++;
               if (got3 !== e3.data) begin
                  errors++;
                  $display("FAIL dut3_rdata: got %h expected %h", got3, e3.data);
               end
            end
            $display("dut3 t=%0t ack %s %s data=%h", $time, e3.dma ? "DMA" : "CPU", e3.rd ? "RD" : "WR", got3);
         end
      end
   end

   // ---------------- drive helpers ----------------
   task automatic cpu1(input logic req, input logic we, input logic [23:0] a, input logic [15:0] d);
      b1.cpu_req = req; b1.cpu_we = we; b1.cpu_addr = a; b1.cpu_wdata = d;
   endtask
   task automatic dma1(input logic req, input logic we, input logic [23:0] a, input logic [15:0] d);
      b1.dma_req = req; b1.dma_we = we; b1.dma_addr = a; b1.dma_wdata = d;
   endtask
   task automatic cpu3(input logic req, input logic we, input logic [23:0] a, input logic [15:0] d);
      b3.cpu_req = req; b3.cpu_we = we; b3.cpu_addr = a; b3.cpu_wdata = d;
   endtask
   task automatic dma3(input logic req, input logic we, input logic [23:0] a, input logic [15:0] d);
      b3.dma_req = req; b3.dma_we = we; b3.dma_addr = a; b3.dma_wdata = d;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      cpu1(1, 1, 24'h55, 16'hA5A5); dma1(1, 1, 24'h66, 16'h5A5A);
      cpu3(1, 1, 24'h55, 16'hA5A5); dma3(1, 1, 24'h66, 16'h5A5A);
      sb1.push_back(mk(0, 0, 16'h0));
      sb3.push_back(mk(0, 0, 16'h0));
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({b1.mem_en, b1.mem_we, b1.cpu_ack, b1.dma_ack, b1.dma_gnt} !== 5'b0 ||
             b1.mem_addr !== 24'h0 || b1.mem_wdata !== 16'h0 ||
             b1.cpu_rdata !== 16'h0 || b1.dma_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs_dut1: en/we/cack/dack/gnt=%b addr=%h wdata=%h crd=%h drd=%h expected all 0",
                     {b1.mem_en, b1.mem_we, b1.cpu_ack, b1.dma_ack, b1.dma_gnt}, b1.mem_addr, b1.mem_wdata, b1.cpu_rdata, b1.dma_rdata);
         end
         checks++;
         if ({b3.mem_en, b3.mem_we, b3.cpu_ack, b3.dma_ack, b3.dma_gnt} !== 5'b0 ||
             b3.mem_addr !== 24'h0 || b3.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs_dut3: en/we/cack/dack/gnt=%b addr=%h wdata=%h expected all 0",
                     {b3.mem_en, b3.mem_we, b3.cpu_ack, b3.dma_ack, b3.dma_gnt}, b3.mem_addr, b3.mem_wdata);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.mem_we, b1.cpu_ack, b1.dma_gnt} !== 4'b1110 || b1.mem_addr !== 24'h55) begin
         errors++;
         $display("FAIL reset_first_issue_dut1: en/we/cack/gnt=%b addr=%h expected 1110 addr=000055",
                  {b1.mem_en, b1.mem_we, b1.cpu_ack, b1.dma_gnt}, b1.mem_addr);
      end
      checks++;
      if ({b3.mem_en, b3.mem_we, b3.cpu_ack, b3.dma_gnt} !== 4'b1110 || b3.mem_addr !== 24'h55) begin
         errors++;
         $display("FAIL reset_first_issue_dut3: en/we/cack/gnt=%b addr=%h expected 1110 addr=000055",
                  {b3.mem_en, b3.mem_we, b3.cpu_ack, b3.dma_gnt}, b3.mem_addr);
      end
      cpu1(0, 0, 24'h0, 16'h0); dma1(0, 0, 24'h0, 16'h0);
      cpu3(0, 0, 24'h0, 16'h0); dma3(0, 0, 24'h0, 16'h0);
      @(negedge clk);
   endtask

   task automatic test_cpu_write_read;
      cpu1(1, 1, 24'h001234, 16'hBEEF);
      sb1.push_back(mk(0, 0, 16'h0));
      #1;
      checks++;
      if (b1.cpu_stall !== 1'b1) begin
         errors++;
         $display("FAIL wr_stall_c0: got %b expected 1", b1.cpu_stall);
      end
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.mem_we, b1.cpu_ack, b1.cpu_stall} !== 4'b1110 ||
          b1.mem_addr !== 24'h001234 || b1.mem_wdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL wr_issue_c1: en/we/ack/stall=%b addr=%h wdata=%h expected 1110 001234 beef",
                  {b1.mem_en, b1.mem_we, b1.cpu_ack, b1.cpu_stall}, b1.mem_addr, b1.mem_wdata);
      end
      cpu1(0, 0, 24'h0, 16'h0);
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.mem_we, b1.cpu_ack} !== 3'b000) begin
         errors++;
         $display("FAIL wr_bubble: en/we/ack=%b expected 000", {b1.mem_en, b1.mem_we, b1.cpu_ack});
      end
      cpu1(1, 0, 24'h001234, 16'h0);
      sb1.push_back(mk(0, 1, 16'hBEEF));
      #1;
      checks++;
      if (b1.cpu_stall !== 1'b1) begin
         errors++;
         $display("FAIL rd_stall_c0: got %b expected 1", b1.cpu_stall);
      end
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.mem_we, b1.cpu_ack, b1.cpu_stall} !== 4'b1001) begin
         errors++;
         $display("FAIL rd_issue_c1: en/we/ack/stall=%b expected 1001", {b1.mem_en, b1.mem_we, b1.cpu_ack, b1.cpu_stall});
      end
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.cpu_ack, b1.cpu_stall} !== 3'b010 || b1.cpu_rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL rd_ack_c2: en/ack/stall=%b rdata=%h expected 010 beef",
                  {b1.mem_en, b1.cpu_ack, b1.cpu_stall}, b1.cpu_rdata);
      end
      cpu1(0, 0, 24'h0, 16'h0);
      @(negedge clk);
      checks++;
      if (b1.cpu_rdata !== 16'hBEEF || b1.cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL rd_hold: rdata=%h ack=%b expected beef 0", b1.cpu_rdata, b1.cpu_ack);
      end
   endtask

   task automatic test_contention;
      int n;
      for (int k = 0; k < 2; k++) begin
         repeat (4) sb1.push_back(mk(0, 0, 16'h0));
         sb1.push_back(mk(1, 0, 16'h0));
      end
      cpu1(1, 1, 24'h10, 16'h1111);
      dma1(1, 1, 24'h20, 16'h2222);
      n = 0;
      for (int i = 0; i < 60 && n < 10; i++) begin
         @(negedge clk);
         if (b1.cpu_ack || b1.dma_ack) n++;
         if (n == 10) begin
            cpu1(0, 0, 24'h0, 16'h0);
            dma1(0, 0, 24'h0, 16'h0);
         end
      end
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL contention_acks: got %0d acks expected 10", n);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int t1, t2, n;
      sb1.push_back(mk(1, 1, 16'h2222));
      sb1.push_back(mk(1, 1, 16'h2222));
      dma1(1, 0, 24'h20, 16'h0);
      t1 = 0; t2 = 0; n = 0;
      for (int c = 1; c <= 10 && n < 2; c++) begin
         @(negedge clk);
         if (b1.dma_ack) begin
            n++;
            if (n == 1) t1 = c;
            else begin
               t2 = c;
               dma1(0, 0, 24'h0, 16'h0);
            end
         end
      end
      checks++;
      if (t1 != 2 || t2 != 5) begin
         errors++;
         $display("FAIL back_to_back_timing: acks at %0d,%0d expected 2,5", t1, t2);
      end
      @(negedge clk);
   endtask

   task automatic test_dma_then_cpu;
      int k;
      dma3(1, 0, 24'h55, 16'h0);
      sb3.push_back(mk(1, 1, 16'hA5A5));
      @(negedge clk);  // cycle 1: ISSUE
      checks++;
      if ({b3.dma_gnt, b3.mem_en, b3.mem_we} !== 3'b110 || b3.mem_addr !== 24'h55) begin
         errors++;
         $display("FAIL dma_issue: gnt/en/we=%b addr=%h expected 110 000055", {b3.dma_gnt, b3.mem_en, b3.mem_we}, b3.mem_addr);
      end
      @(negedge clk);  // cycle 2: WAIT, CPU request rises
      cpu3(1, 0, 24'h55, 16'h0);
      sb3.push_back(mk(0, 1, 16'hA5A5));
      #1;
      checks++;
      if ({b3.cpu_stall, b3.dma_gnt, b3.dma_ack} !== 3'b110) begin
         errors++;
         $display("FAIL dma_wait_c2: stall/gnt/dack=%b expected 110", {b3.cpu_stall, b3.dma_gnt, b3.dma_ack});
      end
      @(negedge clk);  // cycle 3
      checks++;
      if ({b3.cpu_stall, b3.dma_gnt, b3.dma_ack} !== 3'b110) begin
         errors++;
         $display("FAIL dma_wait_c3: stall/gnt/dack=%b expected 110", {b3.cpu_stall, b3.dma_gnt, b3.dma_ack});
      end
      @(negedge clk);  // cycle 4: DMA ack
      checks++;
      if ({b3.cpu_stall, b3.dma_gnt, b3.dma_ack, b3.cpu_ack} !== 4'b1110 || b3.cpu_rdata !== 16'h0) begin
         errors++;
         $display("FAIL dma_ack_c4: stall/gnt/dack/cack=%b cpu_rdata=%h expected 1110 0000",
                  {b3.cpu_stall, b3.dma_gnt, b3.dma_ack, b3.cpu_ack}, b3.cpu_rdata);
      end
      dma3(0, 0, 24'h0, 16'h0);
      @(negedge clk);  // cycle 5: bubble
      checks++;
      if ({b3.mem_en, b3.dma_gnt, b3.cpu_stall, b3.cpu_ack} !== 4'b0010) begin
         errors++;
         $display("FAIL dma_bubble: en/gnt/stall/cack=%b expected 0010", {b3.mem_en, b3.dma_gnt, b3.cpu_stall, b3.cpu_ack});
      end
      @(negedge clk);  // cycle 6: CPU ISSUE
      checks++;
      if ({b3.mem_en, b3.mem_we, b3.dma_gnt} !== 3'b100 || b3.mem_addr !== 24'h55) begin
         errors++;
         $display("FAIL cpu_after_dma_issue: en/we/gnt=%b addr=%h expected 100 000055", {b3.mem_en, b3.mem_we, b3.dma_gnt}, b3.mem_addr);
      end
      k = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (b3.cpu_ack) begin
            k = c;
            cpu3(0, 0, 24'h0, 16'h0);
            break;
         end
      end
      checks++;
      if (k != 3) begin
         errors++;
         $display("FAIL cpu_after_dma_ack: ack %0d cycles after issue expected 3", k);
      end
      @(negedge clk);
   endtask

   task automatic test_rd_lat3;
      int en_cnt, ack_at;
      dma3(1, 1, 24'h77, 16'h1357);
      sb3.push_back(mk(1, 0, 16'h0));
      @(negedge clk);
      checks++;
      if ({b3.dma_ack, b3.mem_en, b3.mem_we, b3.dma_gnt} !== 4'b1111) begin
         errors++;
         $display("FAIL lat3_write: dack/en/we/gnt=%b expected 1111", {b3.dma_ack, b3.mem_en, b3.mem_we, b3.dma_gnt});
      end
      dma3(0, 0, 24'h0, 16'h0);
      @(negedge clk);
      dma3(1, 0, 24'h77, 16'h0);
      sb3.push_back(mk(1, 1, 16'h1357));
      en_cnt = 0; ack_at = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (b3.mem_en === 1'b1) en_cnt++;
         if (b3.dma_ack === 1'b1 && ack_at == 0) begin
            ack_at = c;
            dma3(0, 0, 24'h0, 16'h0);
         end
      end
      checks++;
      if (en_cnt != 1 || ack_at != 4) begin
         errors++;
         $display("FAIL lat3_timing: mem_en cycles=%0d ack at %0d expected 1 and 4", en_cnt, ack_at);
      end
      noise3 = 16'hFFFF;
      @(negedge clk);
      checks++;
      if (b3.dma_rdata !== 16'h1357 || b3.cpu_rdata !== 16'hA5A5) begin
         errors++;
         $display("FAIL lat3_hold: dma_rdata=%h cpu_rdata=%h expected 1357 a5a5", b3.dma_rdata, b3.cpu_rdata);
      end
      noise3 = 16'h0;
      @(negedge clk);
   endtask

   task automatic test_reset_wait;
      int n;
      cpu3(1, 0, 24'h77, 16'h0);
      dma3(1, 0, 24'h77, 16'h0);
      sb3.push_back(mk(0, 1, 16'h1357));
      @(negedge clk);  // cycle 1: ISSUE (CPU)
      checks++;
      if ({b3.mem_en, b3.dma_gnt, b3.cpu_ack} !== 3'b100) begin
         errors++;
         $display("FAIL rstw_issue: en/gnt/cack=%b expected 100", {b3.mem_en, b3.dma_gnt, b3.cpu_ack});
      end
      @(negedge clk);  // cycle 2: WAIT
      @(negedge clk);  // cycle 3: WAIT, assert reset
      rst = 1'b1;
      sb3.delete();
      repeat (4) sb3.push_back(mk(0, 1, 16'h1357));
      sb3.push_back(mk(1, 1, 16'h1357));
      #1;
      checks++;
      if ({b3.cpu_ack, b3.dma_ack} !== 2'b00) begin
         errors++;
         $display("FAIL rstw_no_ack_c3: cack/dack=%b expected 00", {b3.cpu_ack, b3.dma_ack});
      end
      @(negedge clk);  // cycle 4: IDLE under reset
      checks++;
      if ({b3.mem_en, b3.cpu_ack, b3.dma_ack, b3.dma_gnt} !== 4'b0000 ||
          b3.mem_addr !== 24'h0 || b3.cpu_rdata !== 16'h0 || b3.dma_rdata !== 16'h0) begin
         errors++;
         $display("FAIL rstw_idle: en/cack/dack/gnt=%b addr=%h crd=%h drd=%h expected 0000 0 0 0",
                  {b3.mem_en, b3.cpu_ack, b3.dma_ack, b3.dma_gnt}, b3.mem_addr, b3.cpu_rdata, b3.dma_rdata);
      end
      rst = 1'b0;
      @(negedge clk);  // cycle 5: reissue
      checks++;
      if ({b3.mem_en, b3.mem_we, b3.dma_gnt} !== 3'b100 || b3.mem_addr !== 24'h77) begin
         errors++;
         $display("FAIL rstw_reissue: en/we/gnt=%b addr=%h expected 100 000077", {b3.mem_en, b3.mem_we, b3.dma_gnt}, b3.mem_addr);
      end
      n = 0;
      for (int i = 0; i < 40 && n < 5; i++) begin
         @(negedge clk);
         if (b3.cpu_ack || b3.dma_ack) n++;
         if (n == 5) begin
            cpu3(0, 0, 24'h0, 16'h0);
            dma3(0, 0, 24'h0, 16'h0);
         end
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL rstw_acks: got %0d acks expected 5", n);
      end
      @(negedge clk);
   endtask

   initial begin
      cpu1(0, 0, 24'h0, 16'h0); dma1(0, 0, 24'h0, 16'h0);
      cpu3(0, 0, 24'h0, 16'h0); dma3(0, 0, 24'h0, 16'h0);
      repeat (2) @(negedge clk);
      test_reset();
      test_cpu_write_read();
      test_contention();
      test_back_to_back();
      test_dma_then_cpu();
      test_rd_lat3();
      test_reset_wait();
      repeat (2) @(negedge clk);
      checks++;
      if (sb1.size() != 0 || sb3.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d/%0d acks outstanding expected 0/0", sb1.size(), sb3.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
